cmp_stream_minmax: RTL



---
 rtl/cmp_pkg.sv | 13 +
 rtl/cmp_stream_minmax_mag_cmp.sv | 19 +
 rtl/cmp_stream_minmax.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and default sizes for the streaming min/max tracker.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CMP_WIDTH = 4;
  localparam int CMP_CNT_W = 8;

endpackage

// File: rtl/cmp_stream_minmax_mag_cmp.sv
// Unsigned magnitude comparator: reports a<b, a>b and a==b.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  // Plain unsigned compares; exactly one output is high at any time.
  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/cmp_stream_minmax.sv
// Streaming min/max tracker: accumulates min, max and a saturating sample
// count over a framed valid/ready stream and presents the result at frame end.
module cmp_stream_minmax
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int CNT_W = CMP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_eq_all
);

  state_t           state;
  logic [WIDTH-1:0] run_min;
  logic [WIDTH-1:0] run_max;
  logic [CNT_W-1:0] run_cnt;

  logic [WIDTH-1:0] nxt_min;
  logic [WIDTH-1:0] nxt_max;
  logic [CNT_W-1:0] nxt_cnt;

  logic lt_min, gt_min, eq_min;
  logic lt_max, gt_max, eq_max;
  logic unused_cmp;
  logic accept;

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) sat_inc = c;
    else                    sat_inc = c + 1'b1;
  endfunction

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (run_min),
    .lt (lt_min),
    .gt (gt_min),
    .eq (eq_min)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (run_max),
    .lt (lt_max),
    .gt (gt_max),
    .eq (eq_max)
  );

  // Only lt against min and gt against max steer the datapath.
  assign unused_cmp = &{1'b0, gt_min, eq_min, lt_max, eq_max};

  // in_ready is registered, so accept never depends on out_ready.
  assign accept = in_valid && in_ready;

  // Candidate running values if the current sample is accepted.
  always_comb begin
    nxt_min = run_min;
    nxt_max = run_max;
    nxt_cnt = run_cnt;
    if (state == IDLE) begin
      nxt_min = in_data;
      nxt_max = in_data;
      nxt_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      if (lt_min) nxt_min = in_data;
      if (gt_max) nxt_max = in_data;
      nxt_cnt = sat_inc(run_cnt);
    end
  end

  // Frame FSM with registered handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_min    <= '0;
      run_max    <= '0;
      run_cnt    <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_count  <= '0;
      out_eq_all <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            run_min <= nxt_min;
            run_max <= nxt_max;
            run_cnt <= nxt_cnt;
            if (in_last) begin
              out_min    <= nxt_min;
              out_max    <= nxt_max;
              out_count  <= nxt_cnt;
              out_eq_all <= (nxt_min == nxt_max);
              out_valid  <= 1'b1;
              in_ready   <= 1'b0;
              state      <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
